// File: rtl/seq_div_pkg.sv
// Shared widths, state encoding and latency for the sequential signed divider.
package seq_div_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int QW_DEFAULT = 2 * DW_DEFAULT;
  localparam int ITER_DEFAULT = QW_DEFAULT;
  // Edges from the accepting edge until ready is high again with the result.
  localparam int LATENCY = ITER_DEFAULT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_divider_signed_div_step.sv
// One restoring division step: shift in the next dividend bit, try to subtract |B|.
module div_step
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW:0] rem_in,
  input  logic        bit_in,
  input  logic [DW-1:0] b_mag,
  output logic [DW:0] rem_out,
  output logic        q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] trial;

  // NOTE: every output is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {2'b00, b_mag};
    q_bit   = ~trial[DW+1];
    rem_out = q_bit ? trial[DW:0] : shifted[DW:0];
  end

endmodule

// File: rtl/seq_divider_signed.sv
// Sequential signed restoring divider: 2*DW / DW -> truncating quotient and remainder,
// one quotient bit per clock, start/ready handshake.
module seq_divider_signed
  import seq_div_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int ITER = 2 * DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2*DW-1:0] A,
  input  logic [DW-1:0]   B,
  output logic [2*DW-1:0] Quotient,
  output logic [DW-1:0]   Remainder,
  output logic            div_by_zero,
  output logic            overflow,
  output logic            ready
);

  localparam int QW = 2 * DW;
  localparam int CW = $clog2(ITER + 1);

  if (ITER != 2 * DW) begin : g_bad_iter
    $error("seq_divider_signed: ITER must equal 2*DW");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW:0]   rem;
  logic [QW-1:0] quo;
  logic [DW-1:0] b_mag;
  logic          a_neg;
  logic          q_neg;
  logic          dz_pend;
  logic          ov_pend;

  logic [QW-1:0] a_mag_c;
  logic [DW-1:0] b_mag_c;
  logic [DW:0]   step_rem;
  logic          step_q;

  // Two's-complement negation of the most negative value wraps to exactly its magnitude.
  assign a_mag_c = A[QW-1] ? -A : A;
  assign b_mag_c = B[DW-1] ? -B : B;

  div_step #(.DW(DW)) u_step (
    .rem_in (rem),
    .bit_in (quo[QW-1]),
    .b_mag  (b_mag),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      b_mag       <= '0;
      a_neg       <= 1'b0;
      q_neg       <= 1'b0;
      dz_pend     <= 1'b0;
      ov_pend     <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      ready       <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem     <= '0;
            quo     <= a_mag_c;
            b_mag   <= b_mag_c;
            a_neg   <= A[QW-1];
            q_neg   <= A[QW-1] ^ B[DW-1];
            dz_pend <= (B == '0);
            ov_pend <= (A == {1'b1, {(QW-1){1'b0}}}) && (B == '1);
            cnt     <= '0;
            ready   <= 1'b0;
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= step_rem;
          quo <= {quo[QW-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= FIX;
        end
        FIX: begin
          if (dz_pend) begin
            Quotient  <= a_neg ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
            Remainder <= '0;
          end else begin
            Quotient  <= q_neg ? -quo : quo;
            Remainder <= a_neg ? -rem[DW-1:0] : rem[DW-1:0];
          end
          div_by_zero <= dz_pend;
          overflow    <= ov_pend;
          ready       <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_divider_signed.md
Name: seq_divider_signed

Overview:
- Sequential signed restoring divider, the inverse companion of the 8x8 signed sequential multiplier.
- Takes a 2*DW-bit signed dividend and a DW-bit signed divisor, and produces a truncating quotient and remainder (Verilog / and % semantics).
- Uses the same start/ready handshake style as the multiplier, so the datapath controller can drive either unit identically.
- Fixed latency, one quotient bit per clock.

Parameters:
- DW, 8, divisor and remainder width. Dividend and quotient width is 2*DW.
- ITER, 2*DW, number of restoring iterations. Must equal 2*DW; a different value is a configuration error.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled on a rising edge only while ready=1.
- A  input  2*DW  signed dividend. Only valid on the edge where start is accepted.
- B  input  DW  signed divisor. Only valid on the edge where start is accepted.
- Quotient  output  2*DW  signed quotient, registered.
- Remainder  output  DW  signed remainder, registered. Its sign follows the dividend.
- div_by_zero  output  1  set with the result when B was 0.
- overflow  output  1  set with the result when A = -2^(2DW-1) and B = -1.
- ready  output  1  high = idle or result valid, can accept start. Low = busy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=1.
  - Quotient=0, Remainder=0, div_by_zero=0, overflow=0.
  - Internal registers cleared.
  - A reset mid-operation aborts with no partial result visible.
- States: IDLE, DIV, FIX, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Capture |A| into the partial-remainder/quotient shift register.
  - Capture |B|, sign(A), sign(A) xor sign(B), and the zero/overflow conditions.
  - Counter=0, ready<=0, go to DIV.
  - A and B are don't-care after E0.
- DIV, edges E1..E(ITER):
  - Shift {rem, quo} left by 1.
  - Trial = rem_hi - |B|, computed one bit wider than DW.
  - If trial >= 0: rem_hi <= trial and the quotient LSB <= 1. Otherwise restore and set the LSB to 0.
  - Counter increments. After ITER iterations, go to FIX.
- FIX, edge E(ITER+1):
  - Negate the quotient magnitude if the result sign is 1. Negate the remainder magnitude if sign(A) is 1.
  - Load Quotient, Remainder, div_by_zero and overflow, set ready<=1, go to DONE.
  - Total latency: ready rises after edge E0+ITER+1, i.e. E17 for DW=8.
- Divide by zero overrides the arithmetic result:
  - Quotient = A>=0 ? +max (0x7FFF) : min (0x8000).
  - Remainder = 0, div_by_zero=1.
  - Latency is unchanged.
- Overflow (-32768 / -1):
  - Quotient = 0x8000 (natural wrap of magnitude 32768), Remainder = 0, overflow=1.
- Magnitude width: |A| up to 2^(2DW-1) must be held unsigned in 2*DW bits, with no loss for the most-negative dividend. |B| up to 2^(DW-1) needs DW bits unsigned.
- Remainder range: |Remainder| < |B| <= 128, so it always fits DW signed bits.
- Start while busy (DIV/FIX) is ignored and has no effect on the operation in flight. A start asserted in the same cycle the unit is in FIX is also ignored.
- Outputs hold their last values in DONE until the next accepted start. At acceptance, the flags and Quotient/Remainder keep their old values until FIX; only ready drops.
- Back-to-back: start accepted in DONE at E17+1 begins a new operation immediately.

Decomposition:
- Package seq_div_pkg:
  - DW default and derived widths QW=2*DW.
  - State encoding localparams IDLE/DIV/FIX/DONE.
  - LATENCY=ITER+1 constant for benches and controllers.
- Sub-module div_step:
  - Combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, |B|.
  - Outputs: new remainder, quotient bit.
- FSM, counter, sign and flag logic stay in seq_divider_signed.

Test Plan:
- A=100, B=7, start for 1 cycle -> ready low for 17 cycles, then Quotient=14, Remainder=2, both flags 0.
- A=-100, B=7 -> Quotient=-14 (0xFFF2), Remainder=-2 (0xFE). Then A=1000, B=-3 -> Quotient=-333 (0xFEB3), Remainder=1.
- A=-32768, B=-1 -> Quotient=0x8000, Remainder=0, overflow=1. Then A=-32768, B=127 -> Quotient=-258, Remainder=-2, overflow=0.
- A=5, B=0 -> Quotient=0x7FFF, Remainder=0, div_by_zero=1. Then A=-5, B=0 -> Quotient=0x8000, Remainder=0, div_by_zero=1.
- Start A=50, B=5; re-assert start with A=9, B=3 at E5; assert rst_n=0 at E10 of a second run -> the first result is still 10/0. The reset forces ready=1 and all outputs 0 asynchronously, and the next start works normally.
- 200 random signed A,B with B!=0 -> results match A/B and A%B. Latency is exactly 17 cycles every time, with back-to-back starts issued in DONE.
